mmcm_rst_seq: RTL and testbench
===============================

# mmcm_rst_seq

Reset sequencer that sits directly upstream of the MMCM clock generator. It runs on the free-running board clock and drives the MMCM `reset` input. It watches the MMCM `locked` output and re-resets the MMCM on lock timeout or lock loss. It releases a system reset request only after lock has been stable for a programmable settle window.

## Interface
Parameters:
- `RST_PULSE`, default 16: MMCM reset pulse length in clocks; must be ≥ 4.
- `LOCK_TIMEOUT`, default 65536: clocks allowed in WAIT_LOCK before a retry.
- `SETTLE_CYCLES`, default 1024: consecutive locked clocks required before RUN.
- `TIMER_W`, default 20: shared timer width; every count parameter must be < 2^TIMER_W.

Ports:
- `clk_in`, input, 1: free-running 100 MHz board clock, the same clock that feeds the MMCM input.
- `reset`, input, 1: asynchronous, active-high; forces state PWR_RST immediately.
- `locked`, input, 1: MMCM lock status, asynchronous to `clk_in`.
- `force_relock`, input, 1: synchronous single-cycle request to rerun the full sequence.
- `mmcm_rst`, output, 1: drives MMCM `reset`, active-high.
- `sys_rst`, output, 1: active-high system reset request; low only in RUN.
- `ready`, output, 1: high only in RUN.
- `retry_count`, output, 4: saturating count of lock timeouts.
- `lock_loss_count`, output, 8: saturating count of lock losses from RUN.

## Operation
- `locked` passes through a 2-flop synchronizer to give `locked_s`. Both flops reset to 0.
- One shared up-counter `timer`, TIMER_W bits wide. It clears on every state change.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- States and transitions (a single rule covers all states):
  - PWR_RST:
    - `mmcm_rst`=1, `sys_rst`=1.
    - On `timer`==RST_PULSE-1, go to WAIT_LOCK.
  - WAIT_LOCK:
    - `mmcm_rst`=0, `sys_rst`=1.
    - If `locked_s`=1, go to SETTLE.
    - Otherwise, on `timer`==LOCK_TIMEOUT-1, go to PWR_RST and increment `retry_count` (saturating).
  - SETTLE:
    - `sys_rst`=1.
    - If `locked_s`=0, go to WAIT_LOCK. The timeout restarts from 0 and no counter changes.
    - Otherwise, on `timer`==SETTLE_CYCLES-1, go to RUN.
  - RUN:
    - `sys_rst`=0, `ready`=1.
    - If `locked_s`=0, go to PWR_RST and increment `lock_loss_count` (saturating).
- `force_relock`=1 overrides all other transitions in every state: go to PWR_RST with no counter change.
- Priority within a cycle: `reset` > `force_relock` > loss of `locked_s` > timer expiry.
- Counters saturate: `retry_count` holds at 15, `lock_loss_count` holds at 255. They clear only on `reset`.

## Timing
- While `reset` is asserted (asynchronous):
  - state = PWR_RST, `timer`=0.
  - `mmcm_rst`=1, `sys_rst`=1, `ready`=0.
  - Both counters = 0, synchronizer flops = 0.
- After `reset` falls, `mmcm_rst` stays high for exactly RST_PULSE rising edges, then falls.
- Every later entry into PWR_RST also gives exactly RST_PULSE cycles of `mmcm_rst`=1.
- Synchronizer latency: a `locked` pin edge appears on `locked_s` 2 edges later.
- Lock to ready: `ready` rises SETTLE_CYCLES+3 edges after the `locked` pin rises in WAIT_LOCK.
- Lock loss: `sys_rst` rises and `ready` falls 3 edges after the `locked` pin falls in RUN. `mmcm_rst` rises on that same edge.
- Timeout:
  - WAIT_LOCK lasts exactly LOCK_TIMEOUT cycles when `locked_s` stays 0.
  - A retry cycle is therefore RST_PULSE+LOCK_TIMEOUT cycles.
- Boundary cases:
  - `locked_s` drops on the SETTLE expiry cycle: go to WAIT_LOCK, never RUN.
  - `locked_s` rises on the WAIT_LOCK timeout cycle: go to SETTLE, with no retry and no increment.
  - `force_relock` in PWR_RST restarts the pulse, with `timer` back to 0.
  - `reset` mid-sequence aborts immediately (asynchronous) and clears the counters.

## Test plan
Test parameters: RST_PULSE=8, LOCK_TIMEOUT=64, SETTLE_CYCLES=16.
- **Power-up lock.**
  - Stimulus: release `reset`; raise `locked` 20 cycles after `mmcm_rst` falls and hold it high.
  - Required: `mmcm_rst` high for 8 edges after release; `ready`/`sys_rst` toggle 19 edges after `locked` rises; both counters 0.
- **Timeout retries.**
  - Stimulus: hold `locked`=0 for 3 full periods (216 cycles).
  - Required: `mmcm_rst` pulses 8 cycles every 72 cycles; `retry_count`=3; then raise `locked` and see `ready` after 19 edges.
- **Settle glitch.**
  - Stimulus: `locked` high for 10 cycles, low for 1, then high.
  - Required: returns to WAIT_LOCK with no RUN, no `mmcm_rst`, counters unchanged; `ready` 19 edges after the second rise.
- **Lock loss in RUN.**
  - Stimulus: drop `locked` for 1 cycle, 5 times, waiting for RUN between each.
  - Required: each drop gives `sys_rst` high 3 edges later and an 8-cycle `mmcm_rst` pulse; `lock_loss_count`=5.
- **Saturation and force.**
  - Stimulus: 20 timeouts; then `force_relock` in RUN.
  - Required: `retry_count` stays at 15; the force gives PWR_RST next edge with `lock_loss_count` unchanged.
- **Async reset mid-SETTLE.**
  - Stimulus: assert `reset` in SETTLE with `lock_loss_count`=2.
  - Required: before the next edge, `mmcm_rst`=1, `sys_rst`=1, `ready`=0, counters=0.

Source files
------------

// File: rtl/mmcm_rst_seq.sv
// ---------------------------------------------------------------------------
// mmcm_rst_seq
//
// Reset sequencer placed in front of an MMCM. It runs on the free-running
// board clock and owns the MMCM reset pin. It pulses the MMCM reset, waits
// for lock, and requires lock to stay stable for a settle window before it
// releases the system reset. It re-resets the MMCM when lock does not arrive
// in time or when lock is lost while running.
//
// Parameters
//   RST_PULSE     : MMCM reset pulse length in clocks (>= 4)
//   LOCK_TIMEOUT  : clocks allowed in WAIT_LOCK before a retry
//   SETTLE_CYCLES : consecutive locked clocks required before RUN
//   TIMER_W       : shared timer width; every count parameter < 2**TIMER_W
//
// Ports
//   clk_in          in   free-running board clock (same one that feeds the MMCM)
//   reset           in   asynchronous active-high reset -> PWR_RST at once
//   locked          in   MMCM lock status, asynchronous to clk_in
//   force_relock    in   single-cycle request to rerun the whole sequence
//   mmcm_rst        out  MMCM reset, active-high (high only in PWR_RST)
//   sys_rst         out  system reset request, active-high (low only in RUN)
//   ready           out  high only in RUN
//   retry_count     out  saturating count of lock timeouts (holds at 15)
//   lock_loss_count out  saturating count of lock losses from RUN (holds at 255)
//
// The FSM state is held in the enum register 'state'. Checkers can bind to
// it directly.
// ---------------------------------------------------------------------------
module mmcm_rst_seq #(
    parameter int RST_PULSE     = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETTLE_CYCLES = 1024,
    parameter int TIMER_W       = 20
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       locked,
    input  logic       force_relock,
    output logic       mmcm_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [1:0] {
        PWR_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    // The timer counts from 0, so each phase ends when it reads (length - 1).
    localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(RST_PULSE - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

    state_t               state;
    state_t               state_nxt;
    logic [TIMER_W-1:0]   timer;
    logic                 timer_clr;
    logic                 retry_inc;
    logic                 loss_inc;

    // Two-flop synchronizer for the asynchronous lock indication.
    logic                 locked_m;
    logic                 locked_s;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    // Next-state selection. force_relock beats everything except the async
    // reset. Lock status is tested before the timer, so a lock change on an
    // expiry cycle wins over the expiry.
    always_comb begin
        state_nxt = state;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        if (force_relock) begin
            state_nxt = PWR_RST;
        end else begin
            unique case (state)
                PWR_RST: begin
                    if (timer == PULSE_LAST) state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = SETTLE;
                    end else if (timer == TIMEOUT_LAST) begin
                        state_nxt = PWR_RST;
                        retry_inc = 1'b1;
                    end
                end
                SETTLE: begin
                    if (!locked_s) begin
                        state_nxt = WAIT_LOCK;
                    end else if (timer == SETTLE_LAST) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_nxt = PWR_RST;
                        loss_inc  = 1'b1;
                    end
                end
                default: state_nxt = PWR_RST;
            endcase
        end
    end

    // force_relock in PWR_RST does not change the state, but it must still
    // restart the pulse. So it clears the timer as well.
    assign timer_clr = force_relock || (state_nxt != state);

    // State, timer, counters and outputs. The outputs are decoded from
    // state_nxt, so they change on the same edge as the state.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state           <= PWR_RST;
            timer           <= '0;
            mmcm_rst        <= 1'b1;
            sys_rst         <= 1'b1;
            ready           <= 1'b0;
            retry_count     <= 4'd0;
            lock_loss_count <= 8'd0;
        end else begin
            state    <= state_nxt;
            // The timer is free to wrap in RUN because nothing reads it there.
            timer    <= timer_clr ? '0 : timer + TIMER_ONE;
            mmcm_rst <= (state_nxt == PWR_RST);
            sys_rst  <= (state_nxt != RUN);
            ready    <= (state_nxt == RUN);
            if (retry_inc && (retry_count != 4'hF)) begin
                retry_count <= retry_count + 4'd1;
            end
            if (loss_inc && (lock_loss_count != 8'hFF)) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mmcm_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_mmcm_rst_seq
//
// Directed bench for mmcm_rst_seq with RST_PULSE=8, LOCK_TIMEOUT=64 and
// SETTLE_CYCLES=16. A phase/countdown model tracks what the outputs must be
// on every cycle. Scenario code adds hand-computed edge counts and values.
// ---------------------------------------------------------------------------
module tb_mmcm_rst_seq;

    localparam int RP = 8;
    localparam int LT = 64;
    localparam int SC = 16;

    // ---------------- clock / reset ----------------
    logic       clk_in       = 1'b0;
    logic       reset        = 1'b0;
    logic       locked       = 1'b0;
    logic       force_relock = 1'b0;
    logic       mmcm_rst;
    logic       sys_rst;
    logic       ready;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    always #5 clk_in = ~clk_in;

    mmcm_rst_seq #(
        .RST_PULSE    (RP),
        .LOCK_TIMEOUT (LT),
        .SETTLE_CYCLES(SC),
        .TIMER_W      (20)
    ) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .locked         (locked),
        .force_relock   (force_relock),
        .mmcm_rst       (mmcm_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks a phase and the number of cycles left in it. Lock is
    // seen through a two-sample delay line.
    localparam int PH_PULSE  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_RUN    = 3;

    int m_phase;
    int m_left;
    int m_retries;
    int m_losses;
    bit m_d1;
    bit m_d2;
    bit m_ls;

    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            m_phase   = PH_PULSE;
            m_left    = RP;
            m_retries = 0;
            m_losses  = 0;
            m_d1      = 0;
            m_d2      = 0;
        end else begin
            m_ls = m_d2;
            m_d2 = m_d1;
            m_d1 = locked;
            if (force_relock) begin
                m_phase = PH_PULSE;
                m_left  = RP;
            end else if (m_phase == PH_PULSE) begin
                m_left--;
                if (m_left == 0) begin m_phase = PH_WAIT; m_left = LT; end
            end else if (m_phase == PH_WAIT) begin
                if (m_ls) begin
                    m_phase = PH_SETTLE; m_left = SC;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = PH_PULSE; m_left = RP;
                        if (m_retries < 15) m_retries++;
                    end
                end
            end else if (m_phase == PH_SETTLE) begin
                if (!m_ls) begin
                    m_phase = PH_WAIT; m_left = LT;
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = PH_RUN;
                end
            end else begin
                if (!m_ls) begin
                    m_phase = PH_PULSE; m_left = RP;
                    if (m_losses < 255) m_losses++;
                end
            end
        end
    end

    // ---------------- scoreboard: every-cycle compare ----------------
    always @(negedge clk_in) begin
        check("cyc_mmcm_rst", int'(mmcm_rst), int'(m_phase == PH_PULSE));
        check("cyc_sys_rst", int'(sys_rst), int'(m_phase != PH_RUN));
        check("cyc_ready", int'(ready), int'(m_phase == PH_RUN));
        check("cyc_retry_count", int'(retry_count), m_retries);
        check("cyc_lock_loss_count", int'(lock_loss_count), m_losses);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Assert reset away from both clock edges and release it on a negedge.
    task automatic do_reset();
        @(negedge clk_in);
        #2;
        reset        = 1'b1;
        locked       = 1'b0;
        force_relock = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_mmcm_fall(output int n);
        n = 0;
        while (mmcm_rst && n < 200) begin
            @(negedge clk_in);
            n++;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 300) begin
            @(negedge clk_in);
            n++;
        end
    endtask

    // One-cycle lock drop from RUN. It checks the reaction delay and the pulse
    // length, then optionally waits until RUN comes back.
    task automatic lose_lock(input bit back_to_run);
        int n;
        locked = 1'b0;
        @(negedge clk_in);
        n      = 1;
        locked = 1'b1;
        while (!sys_rst && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check("loss_sys_rst_delay", n, 3);
        check("loss_mmcm_same_edge", int'(mmcm_rst), 1);
        check("loss_ready_low", int'(ready), 0);
        wait_mmcm_fall(n);
        check("loss_pulse_len", n, RP);
        if (back_to_run) begin
            wait_ready(n);
            check("loss_relock_ready", n, SC + 1);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        int rises;
        bit prev;
        bit seen;

        #1 reset = 1'b1;
        #1;
        check("rst_mmcm_rst", int'(mmcm_rst), 1);
        check("rst_sys_rst", int'(sys_rst), 1);
        check("rst_ready", int'(ready), 0);
        check("rst_retry", int'(retry_count), 0);
        check("rst_loss", int'(lock_loss_count), 0);
        tick(2);
        reset = 1'b0;

        // Power-up lock
        wait_mmcm_fall(n);
        check("pwrup_pulse_len", n, RP);
        tick(20);
        locked = 1'b1;
        wait_ready(n);
        check("pwrup_lock_to_ready", n, SC + 3);
        check("pwrup_sys_rst", int'(sys_rst), 0);
        check("pwrup_retry", int'(retry_count), 0);
        check("pwrup_loss", int'(lock_loss_count), 0);

        // Timeout retries: three full 72-cycle periods
        do_reset();
        rises = 0;
        prev  = 1'b1;
        for (int i = 0; i < 3 * (RP + LT); i++) begin
            @(negedge clk_in);
            if (mmcm_rst && !prev) rises++;
            prev = mmcm_rst;
        end
        check("timeout_pulse_rises", rises, 3);
        check("timeout_retry_count", int'(retry_count), 3);
        check("timeout_mmcm_at_216", int'(mmcm_rst), 1);
        wait_mmcm_fall(n);
        check("timeout_retry_pulse_len", n, RP);
        locked = 1'b1;
        wait_ready(n);
        check("timeout_lock_to_ready", n, SC + 3);

        // Lock arrives on the WAIT_LOCK timeout cycle: no retry
        do_reset();
        tick(RP + LT - 3);
        locked = 1'b1;
        wait_ready(n);
        check("wait_edge_lock_to_ready", n, SC + 3);
        check("wait_edge_no_retry", int'(retry_count), 0);

        // Settle glitch
        do_reset();
        wait_mmcm_fall(n);
        tick(5);
        locked = 1'b1;
        seen   = 1'b0;
        repeat (10) begin
            @(negedge clk_in);
            seen = seen | ready | mmcm_rst;
        end
        locked = 1'b0;
        @(negedge clk_in);
        seen   = seen | ready | mmcm_rst;
        locked = 1'b1;
        wait_ready(n);
        check("glitch_no_run_no_pulse", int'(seen), 0);
        check("glitch_lock_to_ready", n, SC + 3);
        check("glitch_retry", int'(retry_count), 0);
        check("glitch_loss", int'(lock_loss_count), 0);

        // Lock drops exactly on the SETTLE expiry cycle: never RUN
        do_reset();
        wait_mmcm_fall(n);
        tick(3);
        locked = 1'b1;
        tick(SC);
        locked = 1'b0;
        seen   = 1'b0;
        repeat (30) begin
            @(negedge clk_in);
            seen = seen | ready;
        end
        check("settle_edge_no_run", int'(seen), 0);
        locked = 1'b1;
        wait_ready(n);
        check("settle_edge_lock_to_ready", n, SC + 3);

        // Lock loss in RUN, five times
        for (int k = 0; k < 5; k++) lose_lock(1'b1);
        check("loss_count_5", int'(lock_loss_count), 5);
        check("loss_retry_0", int'(retry_count), 0);

        // Saturation, then force_relock
        do_reset();
        tick(20 * (RP + LT));
        check("sat_retry_15", int'(retry_count), 15);
        wait_mmcm_fall(n);
        locked = 1'b1;
        wait_ready(n);
        check("sat_lock_to_ready", n, SC + 3);
        force_relock = 1'b1;
        @(negedge clk_in);
        force_relock = 1'b0;
        check("force_mmcm_next_edge", int'(mmcm_rst), 1);
        check("force_ready_low", int'(ready), 0);
        check("force_sys_rst", int'(sys_rst), 1);
        check("force_loss_unchanged", int'(lock_loss_count), 0);
        check("force_retry_held", int'(retry_count), 15);
        tick(3);
        force_relock = 1'b1;
        @(negedge clk_in);
        force_relock = 1'b0;
        wait_mmcm_fall(n);
        check("force_in_pulse_restart", n, RP);

        // Async reset mid-SETTLE with lock_loss_count=2
        do_reset();
        wait_mmcm_fall(n);
        locked = 1'b1;
        wait_ready(n);
        lose_lock(1'b1);
        lose_lock(1'b0);
        tick(3);
        check("pre_reset_loss_2", int'(lock_loss_count), 2);
        check("pre_reset_not_ready", int'(ready), 0);
        #2 reset = 1'b1;
        #1;
        check("async_mmcm_rst", int'(mmcm_rst), 1);
        check("async_sys_rst", int'(sys_rst), 1);
        check("async_ready", int'(ready), 0);
        check("async_retry", int'(retry_count), 0);
        check("async_loss", int'(lock_loss_count), 0);
        tick(2);
        reset = 1'b0;
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
